modu_unit: RTL and testbench

Two-stage registered arithmetic/compare unit. It takes two 2-bit operands C and D and produces a 3-bit result F. The operation is selected by the 1-bit controls A and B. It is a leaf datapath element for small-operand arithmetic, with one clock domain and no handshake; a new operation may be issued every cycle.

---
 rtl/modu_pkg.sv | 12 +
 rtl/modu_alu.sv | 26 ++
 rtl/modu_unit.sv | 36 +++
 tb/tb_modu_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/modu_pkg.sv
// modu_pkg: opcode encoding and widths shared by the modu_unit datapath
package modu_pkg;
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_ABSDIFF = 2'b01,
        OP_MULSAT  = 2'b10,
        OP_CMP     = 2'b11
    } op_e;
    localparam int OPND_W = 2;
    localparam int RES_W = 3;
    localparam logic [RES_W-1:0] SAT_MAX = 3'd7;
endpackage

// File: rtl/modu_alu.sv
// modu_alu: combinational add / abs-diff / saturating multiply / compare on 2-bit operands
module modu_alu
    import modu_pkg::*;
(
    input  logic [1:0]        op_i,
    input  logic [OPND_W-1:0] c_i,
    input  logic [OPND_W-1:0] d_i,
    output logic [RES_W-1:0]  f_o
);
    logic [3:0] c4, d4, sum, diff, prod;
    logic [RES_W-1:0] sat, cmp;
    op_e op;
    always_comb begin
        op = op_e'(op_i);
        c4 = {2'b00, c_i};
        d4 = {2'b00, d_i};
        sum = c4 + d4;
        diff = c4 > d4 ? c4 - d4 : d4 - c4;
        prod = c4 * d4;
        sat = prod > {1'b0, SAT_MAX} ? SAT_MAX : prod[RES_W-1:0];
        cmp = {c_i > d_i, c_i == d_i, c_i < d_i};
        f_o = op == OP_ADD     ? sum[RES_W-1:0]  :
              op == OP_ABSDIFF ? diff[RES_W-1:0] :
              op == OP_MULSAT  ? sat             : cmp;
    end
endmodule

// File: rtl/modu_unit.sv
// modu_unit: two-stage registered wrapper around modu_alu (input regs, then result reg)
module modu_unit
    import modu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              A,
    input  logic              B,
    input  logic [OPND_W-1:0] C,
    input  logic [OPND_W-1:0] D,
    output logic [RES_W-1:0]  F
);
    logic [1:0] op_q;
    logic [OPND_W-1:0] c_q, d_q;
    logic [RES_W-1:0] f_d, f_q;
    modu_alu u_alu (
        .op_i(op_q),
        .c_i (c_q),
        .d_i (d_q),
        .f_o (f_d)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            c_q <= '0;
            d_q <= '0;
            f_q <= '0;
        end else begin
            op_q <= {B, A};
            c_q <= C;
            d_q <= D;
            f_q <= f_d;
        end
    end
    assign F = f_q;
endmodule

// File: tb/tb_modu_unit.sv
// tb_modu_unit: directed, exhaustive and random checks of modu_unit against an arithmetic model
module tb_modu_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0;
    logic [1:0] C = '0, D = '0;
    logic [2:0] F;
    int total = 0;
    int bad = 0;
    logic [2:0] s1 = '0, s2 = '0, exp_f;

    modu_unit dut (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .F(F));

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input bit a, input bit b, input int c, input int d);
        int op, r;
        op = (b ? 2 : 0) + (a ? 1 : 0);
        if (op == 0) r = c + d;
        else if (op == 1) r = c > d ? c - d : d - c;
        else if (op == 2) r = c * d > 7 ? 7 : c * d;
        else r = (c > d ? 4 : 0) + (c == d ? 2 : 0) + (c < d ? 1 : 0);
        return r[2:0];
    endfunction

    task automatic check(input string tag, input logic [2:0] want);
        total++;
        assert (F === want) else begin
            bad++;
            $error("FAIL %s: F=%b expected %b", tag, F, want);
        end
    endtask

    // Drive one cycle of inputs, advance the two-deep expected pipeline, compare F.
    task automatic step(input bit a, input bit b, input int c, input int d, input bit r, input string tag);
        A = a;
        B = b;
        C = c[1:0];
        D = d[1:0];
        rst = r;
        @(posedge clk);
        s2 = r ? 3'd0 : s1;
        s1 = r ? 3'd0 : model(a, b, c, d);
        exp_f = s2;
        #1;
        check(tag, exp_f);
    endtask

    // Issue one op, flush with ADD 0+0, then compare against a hand-derived constant.
    task automatic spot(input bit a, input bit b, input int c, input int d, input logic [2:0] lit, input string tag);
        step(a, b, c, d, 0, {tag, "_issue"});
        step(0, 0, 0, 0, 0, {tag, "_lat1"});
        check(tag, lit);
    endtask

    initial begin
        #1;
        step(1, 1, 3, 0, 1, "rst_hold0");
        check("rst_zero0", 3'd0);
        step(1, 1, 3, 0, 1, "rst_hold1");
        check("rst_zero1", 3'd0);
        step(1, 1, 3, 0, 0, "rst_rel0");
        check("rst_rel_zero", 3'd0);
        step(1, 1, 3, 0, 0, "rst_rel1");
        check("rst_first_cmp", 3'b100);

        for (int i = 0; i < 16; i++) step(0, 0, i / 4, i % 4, 0, $sformatf("add_%0d_%0d", i / 4, i % 4));

        spot(0, 0, 3, 3, 3'd6, "add33");
        spot(0, 0, 2, 1, 3'd3, "add21");
        spot(0, 0, 0, 0, 3'd0, "add00");
        spot(1, 0, 1, 3, 3'd2, "abs13");
        spot(1, 0, 3, 1, 3'd2, "abs31");
        spot(1, 0, 2, 2, 3'd0, "abs22");
        spot(0, 1, 2, 3, 3'd6, "mul23");
        spot(0, 1, 3, 3, 3'd7, "mul33_sat");
        spot(0, 1, 0, 3, 3'd0, "mul03");
        spot(1, 1, 2, 1, 3'b100, "cmp21");
        spot(1, 1, 2, 2, 3'b010, "cmp22");
        spot(1, 1, 0, 3, 3'b001, "cmp03");

        for (int i = 0; i < 64; i++) begin
            step(i[0], i[1], (i >> 2) & 3, (i >> 4) & 3, 0, $sformatf("exh_%0d", i));
            if (i == 30) begin
                step(1, 1, 3, 3, 1, "mid_rst");
                check("mid_rst_flush0", 3'd0);
                step(0, 1, 3, 3, 0, "mid_rst_after");
                check("mid_rst_flush1", 3'd0);
            end
        end

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 19) == 0, $sformatf("rnd_%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
